exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage.sv | 272 +++++++++++++++++++++++++++
 tb/tb_exe_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage -- execute stage of a 32-bit in-order pipeline.
//
// Purpose:
//   Takes one decoded instruction per cycle from the issue slot, runs it
//   through the ALU (or the address adder for loads/stores) and registers the
//   result plus the forwarded control bits into the EX/MEM output register.
//   Keeps the architectural {N,Z,C,V} status register, which is updated only
//   by flag-setting ALU instructions that are actually captured.
//   Branch outcome and target are produced combinationally from the issue
//   slot so the front end can redirect in the same cycle.
//
// Configuration:
//   EXE_BRANCH_ADDR_EN  defined   -> branch_addr = pc_in + (sext(imm24) << 2)
//                       undefined -> branch_addr = 0 (ports still present)
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst            in   1   asynchronous, active-low reset
//   valid_in       in   1   issue slot holds an instruction
//   exe_cmd        in   4   ALU command
//   mem_read       in   1   load  (ALU computes val_rn + val2 address)
//   mem_write      in   1   store (ALU computes val_rn + val2 address)
//   wb_en          in   1   instruction writes a register
//   s_in           in   1   instruction requests a status update
//   b_in           in   1   instruction is a branch
//   val_rn         in  32   first operand
//   val2           in  32   second operand (already shifted / immediate)
//   st_val_in      in  32   store data, forwarded unchanged
//   dest_in        in   4   destination register index
//   pc_in          in  32   PC used as the branch base
//   imm24          in  24   signed word offset of the branch
//   freeze         in   1   hold every register, including status
//   flush          in   1   kill the instruction currently being captured
//   valid_out      out  1   registered: output slot holds an instruction
//   alu_result     out 32   registered ALU / address result
//   st_val         out 32   registered store data
//   dest           out  4   registered destination index
//   wb_en_out      out  1   registered write-back enable
//   mem_read_out   out  1   registered load flag
//   mem_write_out  out  1   registered store flag
//   status         out  4   registered {N,Z,C,V}
//   branch_taken   out  1   combinational: valid_in & b_in & ~flush
//   branch_addr    out 32   combinational branch target (see configuration)
// -----------------------------------------------------------------------------
module exe_stage (
  input  logic        clk,
  input  logic        rst,

  input  logic        valid_in,
  input  logic [3:0]  exe_cmd,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        wb_en,
  input  logic        s_in,
  input  logic        b_in,
  input  logic [31:0] val_rn,
  input  logic [31:0] val2,
  input  logic [31:0] st_val_in,
  input  logic [3:0]  dest_in,
  input  logic [31:0] pc_in,
  input  logic [23:0] imm24,

  input  logic        freeze,
  input  logic        flush,

  output logic        valid_out,
  output logic [31:0] alu_result,
  output logic [31:0] st_val,
  output logic [3:0]  dest,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  status,

  output logic        branch_taken,
  output logic [31:0] branch_addr
);

  // ---------------------------------------------------------------------------
  // Command encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,  // also CMP
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,  // also TST
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000
  } alu_cmd_e;

  // Status bit positions inside {N,Z,C,V}.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic        valid_q;
  logic [31:0] result_q;
  logic [31:0] st_val_q;
  logic [3:0]  dest_q;
  logic        wb_en_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [3:0]  status_q;

  logic [31:0] result_d;
  logic [3:0]  status_d;

  alu_cmd_e    cmd;
  logic        mem_op;
  logic        capture;

  assign cmd     = alu_cmd_e'(exe_cmd);
  assign mem_op  = mem_read | mem_write;
  // Freeze gates capture here so it also wins over flush for status.
  assign capture = valid_in & ~freeze & ~flush;

  // ---------------------------------------------------------------------------
  // Shared 33-bit adder
  // Subtraction is a + ~b + cin: SUB uses cin=1, SBC uses cin=C, which gives
  // a - b - (~C). The carry out is then directly NOT borrow, so add- and
  // subtract-type ops take C from the same bit.
  // ---------------------------------------------------------------------------
  logic [31:0] adder_b;
  logic        adder_cin;
  logic [32:0] adder_sum;

  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    adder_b   = val2;
    adder_cin = 1'b0;
    if (!mem_op) begin
      case (cmd)
        CMD_ADC: adder_cin = status_q[FLAG_C];
        CMD_SUB: begin
          adder_b   = ~val2;
          adder_cin = 1'b1;
        end
        CMD_SBC: begin
          adder_b   = ~val2;
          adder_cin = status_q[FLAG_C];
        end
        default: ;
      endcase
    end
  end

  assign adder_sum = {1'b0, val_rn} + {1'b0, adder_b} + {32'd0, adder_cin};

  // ---------------------------------------------------------------------------
  // Result select and flag classification
  //   arith_op : ADD/ADC/SUB/SBC, updates all four flags
  //   known_op : any legal encoding; unknown codes leave status untouched
  // ---------------------------------------------------------------------------
  logic arith_op;
  logic known_op;

  always_comb begin
    result_d = '0;
    arith_op = 1'b0;
    known_op = 1'b1;
    if (mem_op) begin
      // Loads and stores always form the address, whatever exe_cmd says.
      result_d = adder_sum[31:0];
    end else begin
      case (cmd)
        CMD_MOV: result_d = val2;
        CMD_MVN: result_d = ~val2;
        CMD_ADD,
        CMD_ADC,
        CMD_SUB,
        CMD_SBC: begin
          result_d = adder_sum[31:0];
          arith_op = 1'b1;
        end
        CMD_AND: result_d = val_rn & val2;
        CMD_ORR: result_d = val_rn | val2;
        CMD_EOR: result_d = val_rn ^ val2;
        default: known_op = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next status
  // Overflow: both addends (after the ~b for subtraction) share a sign and
  // the sum's sign differs from it.
  // ---------------------------------------------------------------------------
  logic flag_update;
  logic new_c;
  logic new_v;

  assign flag_update = capture & s_in & ~mem_read & ~mem_write & ~b_in & known_op;

  assign new_c = arith_op ? adder_sum[32] : status_q[FLAG_C];
  assign new_v = arith_op ? ((val_rn[31] == adder_b[31]) && (adder_sum[31] != val_rn[31]))
                          : status_q[FLAG_V];

  always_comb begin
    status_d = status_q;
    if (flag_update) begin
      status_d[FLAG_N] = result_d[31];
      status_d[FLAG_Z] = (result_d == 32'd0);
      status_d[FLAG_C] = new_c;
      status_d[FLAG_V] = new_v;
    end
  end

  // ---------------------------------------------------------------------------
  // EX/MEM output register and status register
  // Status is written at the same edge as the result, so an ADC/SBC in the
  // following slot reads the freshly written C straight from status_q.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: every register here is a plain flop and is cleared by reset; the
  // block holds no RAM, so nothing is left to come up undefined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      st_val_q    <= '0;
      dest_q      <= '0;
      wb_en_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      status_q    <= '0;
    end else if (!freeze) begin
      valid_q     <= valid_in & ~flush;
      result_q    <= result_d;
      st_val_q    <= st_val_in;
      dest_q      <= dest_in;
      // Killed or empty slots must not write back or touch memory.
      wb_en_q     <= capture & wb_en;
      mem_read_q  <= capture & mem_read;
      mem_write_q <= capture & mem_write;
      status_q    <= status_d;
    end
  end

  assign valid_out     = valid_q;
  assign alu_result    = result_q;
  assign st_val        = st_val_q;
  assign dest          = dest_q;
  assign wb_en_out     = wb_en_q;
  assign mem_read_out  = mem_read_q;
  assign mem_write_out = mem_write_q;
  assign status        = status_q;

  // ---------------------------------------------------------------------------
  // Branch resolution (combinational, independent of freeze)
  // ---------------------------------------------------------------------------
  assign branch_taken = valid_in & b_in & ~flush;

`ifdef EXE_BRANCH_ADDR_EN
  // imm24 is a signed word offset: sign-extend to 30 bits, then x4.
  assign branch_addr = pc_in + {{6{imm24[23]}}, imm24, 2'b00};
`else
  logic unused_branch_bits;
  assign unused_branch_bits = ^{pc_in, imm24};
  assign branch_addr        = '0;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage -- self-checking bench for exe_stage.
// Directed scenarios first, then randomized traffic; every output is compared
// against a behavioural model that works in plain signed/unsigned arithmetic.
// -----------------------------------------------------------------------------
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in, mem_read, mem_write, wb_en, s_in, b_in, freeze, flush;
  logic [3:0]  exe_cmd, dest_in;
  logic [31:0] val_rn, val2, st_val_in, pc_in;
  logic [23:0] imm24;

  logic        valid_out, wb_en_out, mem_read_out, mem_write_out, branch_taken;
  logic [31:0] alu_result, st_val, branch_addr;
  logic [3:0]  dest, status;

  exe_stage dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
    .wb_en(wb_en), .s_in(s_in), .b_in(b_in), .val_rn(val_rn), .val2(val2),
    .st_val_in(st_val_in), .dest_in(dest_in), .pc_in(pc_in), .imm24(imm24),
    .freeze(freeze), .flush(flush),
    .valid_out(valid_out), .alu_result(alu_result), .st_val(st_val), .dest(dest),
    .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .status(status), .branch_taken(branch_taken), .branch_addr(branch_addr)
  );

  always #5 clk = ~clk;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;
  localparam longint TWO32 = 64'sd4294967296;
  localparam longint TWO24 = 64'sd16777216;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the architectural state visible at the outputs.
  logic        m_valid, m_wb, m_mr, m_mw;
  logic [31:0] m_res, m_st;
  logic [3:0]  m_dest, m_status;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
    m_res = '0; m_st = '0; m_dest = '0; m_status = '0;
  endtask

  // Reference ALU: results from 64-bit arithmetic, C from range of the
  // unsigned result, V from range of the signed result.
  task automatic ref_alu(output logic [31:0] res, output logic [3:0] flags, output bit known);
    longint ua, ub, sa, sb, c, u, s;
    bit     arith, is_sub;
    logic   cf, vf;
    ua = longint'(val_rn); ub = longint'(val2);
    sa = $signed(val_rn);  sb = $signed(val2);
    c  = m_status[1] ? 64'sd1 : 64'sd0;
    cf = m_status[1]; vf = m_status[0];
    known = 1; arith = 0; is_sub = 0; u = 0; s = 0; res = '0;
    if (mem_read || mem_write) begin
      u = ua + ub; res = u[31:0];
    end else begin
      case (exe_cmd)
        4'b0001: res = val2;
        4'b1001: res = ~val2;
        4'b0010: begin u = ua + ub;         s = sa + sb;         arith = 1; end
        4'b0011: begin u = ua + ub + c;     s = sa + sb + c;     arith = 1; end
        4'b0100: begin u = ua - ub;         s = sa - sb;         arith = 1; is_sub = 1; end
        4'b0101: begin u = ua - ub - (1-c); s = sa - sb - (1-c); arith = 1; is_sub = 1; end
        4'b0110: res = val_rn & val2;
        4'b0111: res = val_rn | val2;
        4'b1000: res = val_rn ^ val2;
        default: known = 0;
      endcase
      if (arith) begin
        res = u[31:0];
        cf  = is_sub ? (u >= 0) : (u >= TWO32);
        vf  = (s > MAX_S) || (s < MIN_S);
      end
    end
    flags = {res[31], res == 32'd0, cf, vf};
  endtask

  task automatic model_edge();
    logic [31:0] res;
    logic [3:0]  fl;
    bit          known, cap;
    if (freeze) return;
    ref_alu(res, fl, known);
    cap     = valid_in && !flush;
    m_valid = cap;
    m_res   = res;
    m_st    = st_val_in;
    m_dest  = dest_in;
    m_wb    = cap && wb_en;
    m_mr    = cap && mem_read;
    m_mw    = cap && mem_write;
    if (cap && s_in && !mem_read && !mem_write && !b_in && known) m_status = fl;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".valid"},  32'(valid_out),     32'(m_valid));
    check({tag, ".result"}, alu_result,         m_res);
    check({tag, ".st_val"}, st_val,             m_st);
    check({tag, ".dest"},   32'(dest),          32'(m_dest));
    check({tag, ".wb"},     32'(wb_en_out),     32'(m_wb));
    check({tag, ".mr"},     32'(mem_read_out),  32'(m_mr));
    check({tag, ".mw"},     32'(mem_write_out), 32'(m_mw));
    check({tag, ".status"}, 32'(status),        32'(m_status));
  endtask

  task automatic check_branch(input string tag);
    logic [31:0] exp_addr;
    longint      off;
    off = (imm24 >= 24'h800000) ? longint'(imm24) - TWO24 : longint'(imm24);
`ifdef EXE_BRANCH_ADDR_EN
    exp_addr = 32'(longint'(pc_in) + off * 4);
`else
    exp_addr = (off != 0) ? 32'd0 : 32'd0;
`endif
    check({tag, ".br_taken"}, 32'(branch_taken), 32'(valid_in && b_in && !flush));
    check({tag, ".br_addr"},  branch_addr, exp_addr);
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 1 time unit
  // after the rising edge.
  task automatic cycle(input string tag);
    #1;
    check_branch(tag);
    model_edge();
    @(posedge clk);
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    valid_in = 1; exe_cmd = cmd; val_rn = a; val2 = b; s_in = s;
    mem_read = 0; mem_write = 0; b_in = 0; wb_en = 1; freeze = 0; flush = 0;
    st_val_in = $urandom; dest_in = 4'($urandom); pc_in = $urandom; imm24 = 24'($urandom);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'(($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    valid_in = 0; exe_cmd = 0; mem_read = 0; mem_write = 0; wb_en = 0; s_in = 0;
    b_in = 0; val_rn = 0; val2 = 0; st_val_in = 0; dest_in = 0; pc_in = 0; imm24 = 0;
    freeze = 0; flush = 0;
    model_reset();

    // Reset state, with clock edges occurring while rst is low.
    repeat (2) @(negedge clk);
    check_regs("reset");
    rst = 1;

    // ADD 5+7
    set_op(4'b0010, 32'd5, 32'd7, 1);
    cycle("add");
    check("add.const_res", alu_result, 32'd12);
    check("add.const_wb", 32'(wb_en_out), 32'd1);
    check("add.const_st", 32'(status), 32'd0);

    // SUB 3-3, then CMP 0x80000000 - 1
    set_op(4'b0100, 32'd3, 32'd3, 1);
    cycle("sub");
    check("sub.const_st", 32'(status), 32'b0110);
    set_op(4'b0100, 32'h8000_0000, 32'd1, 1); wb_en = 0;
    cycle("cmp");
    check("cmp.const_st", 32'(status), 32'b0011);

    // ADD wrapping to zero, then ADC picks up the fresh carry
    set_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 1);
    cycle("add_wrap");
    check("add_wrap.const_st", 32'(status), 32'b0110);
    set_op(4'b0011, 32'd0, 32'd0, 1);
    cycle("adc");
    check("adc.const_res", alu_result, 32'd1);

    // Load address, status untouched
    set_op(4'b0000, 32'h100, 32'd8, 1); mem_read = 1;
    cycle("load");
    check("load.const_res", alu_result, 32'h108);
    check("load.const_mr", 32'(mem_read_out), 32'd1);
    check("load.const_st", 32'(status), 32'd0);

    // ORR under freeze for 3 cycles, then released
    set_op(4'b0111, 32'h8000_0000, 32'h0F, 1); freeze = 1;
    for (int i = 0; i < 3; i++) begin
      cycle("freeze");
      check("freeze.const_res", alu_result, 32'h108);
    end
    freeze = 0;
    cycle("orr");
    check("orr.const_res", alu_result, 32'h8000_000F);
    check("orr.const_st", 32'(status), 32'b1000);

    // Flush kills the captured instruction
    set_op(4'b0010, 32'd1, 32'd1, 1); mem_write = 1; flush = 1;
    cycle("flush");
    check("flush.const_valid", 32'(valid_out), 32'd0);
    check("flush.const_ctl", 32'({wb_en_out, mem_read_out, mem_write_out}), 32'd0);

    // Freeze wins over flush
    set_op(4'b0010, 32'd2, 32'd3, 0);
    cycle("pre_frz");
    set_op(4'b0110, 32'd9, 32'd9, 1); freeze = 1; flush = 1;
    cycle("frz_flush");
    check("frz_flush.const_valid", 32'(valid_out), 32'd1);
    check("frz_flush.const_res", alu_result, 32'd5);

    // SBC with C=0: 5 - 3 - 1
    set_op(4'b0010, 32'd1, 32'd1, 1);
    cycle("clr_c");
    set_op(4'b0101, 32'd5, 32'd3, 1);
    cycle("sbc");
    check("sbc.const_res", alu_result, 32'd1);

    // Branch: taken, target from pc and negative offset, flags not written
    set_op(4'b0010, 32'h8000_0000, 32'h8000_0000, 1); b_in = 1;
    pc_in = 32'h20; imm24 = 24'hFFFFFE;
    #1;
    check("branch.const_taken", 32'(branch_taken), 32'd1);
`ifdef EXE_BRANCH_ADDR_EN
    check("branch.const_addr", branch_addr, 32'h18);
`else
    check("branch.const_addr", branch_addr, 32'h0);
`endif
    cycle("branch");
    flush = 1;
    cycle("branch_flushed");

    // Reset in the middle of a cycle
    set_op(4'b0010, 32'd10, 32'd20, 1);
    #2 rst = 0;
    #1;
    model_reset();
    check_regs("rst_async");
    @(posedge clk);
    #1;
    check_regs("rst_hold");
    @(negedge clk);
    rst = 1;
    set_op(4'b0100, 32'd9, 32'd4, 1);
    cycle("after_rst");
    check("after_rst.const_st", 32'(status), 32'b0010);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_op(4'($urandom), pick(), pick(), 1'($urandom));
      valid_in  = ($urandom_range(0, 9) < 8);
      wb_en     = 1'($urandom);
      mem_read  = ($urandom_range(0, 9) == 0);
      mem_write = !mem_read && ($urandom_range(0, 9) == 0);
      b_in      = ($urandom_range(0, 99) < 15);
      freeze    = ($urandom_range(0, 99) < 15);
      flush     = ($urandom_range(0, 99) < 10);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
